// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings and default sizes for the CPU memory path
// (arbiter, CPU FSM and IMemory all import this).
package cpu_mem_pkg;

  localparam int DEF_ADDR_W  = 10;
  localparam int DEF_DATA_W  = 32;
  localparam int DEF_TIMEOUT = 15;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  typedef enum logic {
    GNT_IF = 1'b0,
    GNT_DM = 1'b1
  } gnt_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Fetch port, data port and memory-side signals of the shared memory arbiter.
// slave = arbiter view, master = requesters plus memory.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = cpu_mem_pkg::DEF_ADDR_W,
  parameter int DATA_W = cpu_mem_pkg::DEF_DATA_W
) ();

  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_done;
  logic [DATA_W-1:0] if_rdata;
  logic              if_err;

  logic              dm_req;
  logic              dm_we;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic              dm_done;
  logic [DATA_W-1:0] dm_rdata;
  logic              dm_err;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ready;

  logic              busy;

  modport slave (
    input  if_req, if_addr,
    output if_done, if_rdata, if_err,
    input  dm_req, dm_we, dm_addr, dm_wdata,
    output dm_done, dm_rdata, dm_err,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ready,
    output busy
  );

  modport master (
    output if_req, if_addr,
    input  if_done, if_rdata, if_err,
    output dm_req, dm_we, dm_addr, dm_wdata,
    input  dm_done, dm_rdata, dm_err,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ready,
    input  busy
  );

endinterface

// File: rtl/mem_port_arbiter_timeout_ctr.sv
// Loadable up-counter measuring BUSY cycles; expire_o flags the last allowed
// cycle. A TIMEOUT of 0 disables expiry entirely.
module mem_timeout_ctr #(
  parameter  int TIMEOUT = cpu_mem_pkg::DEF_TIMEOUT,
  localparam int CW      = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          clr_i,
  input  logic          load_i,
  input  logic [CW-1:0] load_val_i,
  input  logic          en_i,
  output logic          expire_o
);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (en_i) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // cnt_q counts completed BUSY cycles, so TIMEOUT-1 marks the TIMEOUT-th one
  generate
    if (TIMEOUT == 0) begin : g_off
      assign expire_o = 1'b0;
    end else begin : g_on
      assign expire_o = en_i && (cnt_q == CW'(TIMEOUT - 1));
    end
  endgenerate

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one single-ported memory between instruction
// fetch and data access, with variable-latency ready and timeout completion.
module mem_port_arbiter
  import cpu_mem_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input logic              clk,
  input logic              reset_n,
  mem_port_arbiter_if.slave bus
);

  state_t            state_q;
  gnt_t              last_q;
  gnt_t              grant_q;
  gnt_t              grant_d;
  logic              mem_en_q;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic              if_done_q;
  logic              if_err_q;
  logic [DATA_W-1:0] if_rdata_q;
  logic              dm_done_q;
  logic              dm_err_q;
  logic [DATA_W-1:0] dm_rdata_q;
  logic              busy_q;
  logic              tie;
  logic              expire;
  logic              ctr_en;
  logic              ctr_clr;

  // A tie goes to whichever port did not win the previous tie
  always_comb begin
    tie     = bus.if_req && bus.dm_req;
    grant_d = GNT_IF;
    if (tie) begin
      grant_d = (last_q == GNT_IF) ? GNT_DM : GNT_IF;
    end else if (bus.dm_req) begin
      grant_d = GNT_DM;
    end
  end

  assign ctr_en  = (state_q == ST_BUSY);
  assign ctr_clr = !ctr_en || bus.mem_ready || expire;

  mem_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_timeout_ctr (
    .clk        (clk),
    .reset_n    (reset_n),
    .clr_i      (ctr_clr),
    .load_i     (1'b0),
    .load_val_i ('0),
    .en_i       (ctr_en),
    .expire_o   (expire)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      last_q      <= GNT_IF;
      grant_q     <= GNT_IF;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_done_q   <= 1'b0;
      if_err_q    <= 1'b0;
      if_rdata_q  <= '0;
      dm_done_q   <= 1'b0;
      dm_err_q    <= 1'b0;
      dm_rdata_q  <= '0;
      busy_q      <= 1'b0;
    end else begin
      if_done_q <= 1'b0;
      dm_done_q <= 1'b0;
      if_err_q  <= 1'b0;
      dm_err_q  <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (bus.if_req || bus.dm_req) begin
            if (tie) begin
              last_q <= grant_d;
            end
            grant_q     <= grant_d;
            mem_addr_q  <= (grant_d == GNT_DM) ? bus.dm_addr : bus.if_addr;
            mem_we_q    <= (grant_d == GNT_DM) && bus.dm_we;
            mem_wdata_q <= (grant_d == GNT_DM) ? bus.dm_wdata : '0;
            mem_en_q    <= 1'b1;
            busy_q      <= 1'b1;
            state_q     <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (bus.mem_ready) begin
            if (grant_q == GNT_IF) begin
              if_rdata_q <= bus.mem_rdata;
              if_done_q  <= 1'b1;
            end else begin
              if (!mem_we_q) begin
                dm_rdata_q <= bus.mem_rdata;
              end
              dm_done_q <= 1'b1;
            end
            mem_en_q <= 1'b0;
            mem_we_q <= 1'b0;
            state_q  <= ST_RESP;
          end else if (expire) begin
            if (grant_q == GNT_IF) begin
              if_done_q <= 1'b1;
              if_err_q  <= 1'b1;
            end else begin
              dm_done_q <= 1'b1;
              dm_err_q  <= 1'b1;
            end
            mem_en_q <= 1'b0;
            mem_we_q <= 1'b0;
            state_q  <= ST_RESP;
          end
        end
        ST_RESP: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          busy_q   <= 1'b0;
          mem_en_q <= 1'b0;
          mem_we_q <= 1'b0;
          state_q  <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.if_done   = if_done_q;
  assign bus.if_err    = if_err_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.dm_done   = dm_done_q;
  assign bus.dm_err    = dm_err_q;
  assign bus.dm_rdata  = dm_rdata_q;
  assign bus.mem_en    = mem_en_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed table-driven bench for mem_port_arbiter plus hand sequences for
// reset mid-access and a held request.
module tb_mem_port_arbiter;
  import cpu_mem_pkg::*;

  localparam int TO = 15;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(10), .DATA_W(32)) m ();

  mem_port_arbiter #(.ADDR_W(10), .DATA_W(32), .TIMEOUT(TO)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (m.slave)
  );

  typedef struct {
    logic        ifr;
    logic        dmr;
    logic        we;
    logic [9:0]  ia;
    logic [9:0]  da;
    logic [31:0] wd;
    logic [31:0] rd;
    int          lat;     // BUSY cycle in which mem_ready rises; 0 = never
    logic        exp_dm;  // expected winner
  } vec_t;

  int total = 0;
  int bad = 0;
  logic [31:0] exp_if_rd = '0;
  logic [31:0] exp_dm_rd = '0;
  vec_t tbl[10];
  vec_t v;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply(input vec_t r);
    if (r.ifr) m.if_req = 1'b1;
    if (r.dmr) m.dm_req = 1'b1;
    m.if_addr  = r.ia;
    m.dm_addr  = r.da;
    m.dm_we    = r.we;
    m.dm_wdata = r.wd;
  endtask

  task automatic serve(input vec_t r, input bit drop);
    int   n;
    int   en_cnt;
    int   exp_en;
    logic err_exp;
    n = 0;
    en_cnt = 0;
    while (m.mem_en !== 1'b1 && n < 6) begin
      step();
      n++;
    end
    chk("grant_seen", m.mem_en, 1);
    chk("busy_on", m.busy, 1);
    chk("mem_we", m.mem_we, r.exp_dm ? r.we : 1'b0);
    chk("mem_addr", m.mem_addr, r.exp_dm ? r.da : r.ia);
    chk("mem_wdata", m.mem_wdata, r.exp_dm ? r.wd : 32'h0);
    while (m.mem_en === 1'b1 && en_cnt < 40) begin
      en_cnt++;
      m.mem_ready = (en_cnt == r.lat);
      m.mem_rdata = r.rd;
      step();
      m.mem_ready = 1'b0;
    end
    err_exp = (r.lat == 0) || (r.lat > TO);
    exp_en  = err_exp ? TO : r.lat;
    if (!err_exp) begin
      if (!r.exp_dm) exp_if_rd = r.rd;
      else if (!r.we) exp_dm_rd = r.rd;
    end
    chk("en_cycles", en_cnt, exp_en);
    chk("if_done", m.if_done, !r.exp_dm);
    chk("dm_done", m.dm_done, r.exp_dm);
    chk("if_err", m.if_err, !r.exp_dm && err_exp);
    chk("dm_err", m.dm_err, r.exp_dm && err_exp);
    chk("if_rdata", m.if_rdata, exp_if_rd);
    chk("dm_rdata", m.dm_rdata, exp_dm_rd);
    chk("resp_en", m.mem_en, 0);
    if (drop) begin
      if (r.exp_dm) m.dm_req = 1'b0;
      else m.if_req = 1'b0;
    end
    step();
    chk("done_width", m.if_done | m.dm_done, 0);
    chk("idle_busy", m.busy, 0);
  endtask

  initial begin
    m.if_req = 0; m.if_addr = '0; m.dm_req = 0; m.dm_we = 0;
    m.dm_addr = '0; m.dm_wdata = '0; m.mem_rdata = '0; m.mem_ready = 0;

    //          ifr dmr we  ia      da      wd            rd            lat exp_dm
    tbl[0] = '{1'b1, 1'b1, 1'b1, 10'h004, 10'h010, 32'hDEADBEEF, 32'h99999999, 1, 1'b1};
    tbl[1] = '{1'b0, 1'b0, 1'b1, 10'h004, 10'h010, 32'hDEADBEEF, 32'h20080005, 2, 1'b0};
    tbl[2] = '{1'b1, 1'b1, 1'b0, 10'h008, 10'h020, 32'h00000000, 32'h11111111, 1, 1'b0};
    tbl[3] = '{1'b0, 1'b0, 1'b0, 10'h008, 10'h020, 32'h00000000, 32'h22222222, 1, 1'b1};
    tbl[4] = '{1'b1, 1'b1, 1'b1, 10'h008, 10'h030, 32'h12345678, 32'h77777777, 3, 1'b1};
    tbl[5] = '{1'b0, 1'b0, 1'b1, 10'h008, 10'h030, 32'h12345678, 32'h33333333, 1, 1'b0};
    tbl[6] = '{1'b0, 1'b1, 1'b0, 10'h008, 10'h3FF, 32'h00000000, 32'h0000CAFE, 4, 1'b1};
    tbl[7] = '{1'b0, 1'b1, 1'b0, 10'h008, 10'h100, 32'h00000000, 32'h55555555, 0, 1'b1};
    tbl[8] = '{1'b0, 1'b1, 1'b0, 10'h008, 10'h101, 32'h00000000, 32'hBEEF0001, 15, 1'b1};
    tbl[9] = '{1'b1, 1'b0, 1'b0, 10'h004, 10'h101, 32'h00000000, 32'h20080005, 1, 1'b0};

    #12;
    chk("rst_mem_en", m.mem_en, 0);
    chk("rst_busy", m.busy, 0);
    chk("rst_dones", {m.if_done, m.dm_done, m.if_err, m.dm_err}, 0);
    chk("rst_addr", m.mem_addr, 0);
    chk("rst_rdata", m.if_rdata | m.dm_rdata | m.mem_wdata, 0);
    #10 reset_n = 1'b1;
    step();

    for (int i = 0; i < 10; i++) begin
      apply(tbl[i]);
      serve(tbl[i], 1'b1);
    end

    // reset pulled during BUSY abandons the access without a done pulse
    v = '{1'b1, 1'b0, 1'b0, 10'h040, 10'h000, 32'h0, 32'hA5A5A5A5, 1, 1'b0};
    apply(v);
    step();
    step();
    step();
    chk("mid_en", m.mem_en, 1);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_en", m.mem_en, 0);
    chk("arst_busy", m.busy, 0);
    chk("arst_done", m.if_done | m.dm_done, 0);
    chk("arst_rdata", m.if_rdata | m.dm_rdata, 0);
    exp_if_rd = '0;
    exp_dm_rd = '0;
    #2 reset_n = 1'b1;
    serve(v, 1'b1);

    // held request is served again as a new fetch
    v = '{1'b1, 1'b0, 1'b0, 10'h00C, 10'h000, 32'h0, 32'h0BADF00D, 2, 1'b0};
    apply(v);
    serve(v, 1'b0);
    v.rd = 32'h13572468;
    serve(v, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
